// File: rtl/regfile_dump_streamer_pkg.sv
// Shared constants and state encoding for the register-file dump streamer.
// The register file uses the same width and depth constants.
package regfile_dump_streamer_pkg;

    localparam int DATA_W = 16;
    localparam int N_REG  = 32;
    localparam int ADDR_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_streamer.sv
// Walks an inclusive, wrapping register range through the register file's
// second read port and streams one register per beat on a valid/ready port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no reads issued; a pending final beat may still be held
// ST_RUN  | rf_raddr = ptr, output register loads whenever it is free
module regfile_dump_streamer
    import regfile_dump_streamer_pkg::*;
#(
    parameter int P_DATA_W = DATA_W,
    parameter int P_ADDR_W = ADDR_W
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [P_ADDR_W-1:0] first_addr,
    input  logic [P_ADDR_W-1:0] last_addr,
    output logic [P_ADDR_W-1:0] rf_raddr,
    input  logic [P_DATA_W-1:0] rf_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_DATA_W-1:0] out_data,
    output logic [P_ADDR_W-1:0] out_addr,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    dump_state_t         state_q, state_d;
    logic [P_ADDR_W-1:0] ptr_q, ptr_d;
    logic [P_ADDR_W-1:0] end_q, end_d;
    logic                valid_q, valid_d;
    logic [P_DATA_W-1:0] data_q, data_d;
    logic [P_ADDR_W-1:0] addr_q, addr_d;
    logic                last_q, last_d;
    logic                done_q, done_d;

    logic                busy_w;
    logic                load_w;
    logic                xfer_w;

    assign busy_w = (state_q == ST_RUN) || valid_q;
    assign load_w = (state_q == ST_RUN) && (!valid_q || out_ready);
    assign xfer_w = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        done_d  = 1'b0;

        // Abort outranks every other action, including a same-cycle start.
        if (abort && busy_w) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (start && !abort && !busy_w) begin
            state_d = ST_RUN;
            ptr_d   = first_addr;
            end_d   = last_addr;
        end else if (load_w) begin
            data_d  = rf_rdata;
            addr_d  = ptr_q;
            last_d  = (ptr_q == end_q);
            valid_d = 1'b1;
            if (ptr_q == end_q) begin
                state_d = ST_IDLE;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end else if (xfer_w) begin
            // Only the final beat can drain without a reload behind it.
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = last_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            end_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign rf_raddr  = ptr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_last  = last_q;
    assign busy      = busy_w;
    assign done      = done_q;

endmodule
